// File: rtl/debug_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : debug_button_conditioner
// Purpose  : Synchronise, debounce and edge-detect the debug pushbuttons and
//            queue press events as a key code with a valid/ack handshake.
//            Optional auto-repeat on held buttons: DEBUG_BTN_AUTOREPEAT_EN.
// Revision : 1.0
// ============================================================================
module debug_button_conditioner #(
  parameter int N_BTN      = 5,
  parameter int DB_CYCLES  = 50000,
  parameter int REP_DELAY  = 2500000,
  parameter int REP_PERIOD = 500000
) (
  input  logic                       clk_5M,
  input  logic                       Rst,
  input  logic [N_BTN-1:0]           btn_raw,
  input  logic                       key_ack,
  output logic [N_BTN-1:0]           btn_level,
  output logic [N_BTN-1:0]           btn_press,
  output logic [N_BTN-1:0]           btn_release,
  output logic [N_BTN-1:0]           btn_repeat,
  output logic                       key_valid,
  output logic [$clog2(N_BTN)-1:0]   key_code,
  output logic                       key_overrun
);

  localparam int KW   = $clog2(N_BTN);
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d1_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] repeat_q;
  logic [N_BTN-1:0] pend_q;
  logic [N_BTN-1:0] pend_d;
  logic             overrun_q;
  logic             overrun_d;

  logic [N_BTN-1:0] w_flip;
  logic [N_BTN-1:0] w_fire;
  logic [N_BTN-1:0] w_set;
  logic [N_BTN-1:0] w_clr;
  logic             w_valid;
  logic [KW-1:0]    w_code;

  // Per-bit debounce: the new level must persist DB_CYCLES samples in a row.
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;
    logic            flip;

    always_comb begin
      cnt_d = cnt_q;
      flip  = 1'b0;
      if (sync2_q[gi] == level_q[gi]) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_d = '0;
        flip  = 1'b1;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end

    always_ff @(posedge clk_5M) begin
      if (Rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign w_flip[gi] = flip;
  end

`ifdef DEBUG_BTN_AUTOREPEAT_EN
  localparam int REP_W = (REP_DELAY > 1) ? $clog2(REP_DELAY) : 1;
  // Hold counter restarts the cycle after the press pulse, hence the -2.
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REP_DELAY - 2);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REP_PERIOD - 1);

  for (genvar gr = 0; gr < N_BTN; gr++) begin : g_rep
    logic [REP_W-1:0] hold_q;
    logic [REP_W-1:0] hold_d;
    logic             armed_q;
    logic             armed_d;
    logic             fire;

    always_comb begin
      fire    = level_q[gr] & ~press_q[gr] &
                (armed_q ? (hold_q == REP_NEXT) : (hold_q == REP_FIRST));
      hold_d  = hold_q + REP_W'(1);
      armed_d = armed_q;
      if (!level_q[gr] || press_q[gr]) begin
        hold_d  = '0;
        armed_d = 1'b0;
      end else if (fire) begin
        hold_d  = '0;
        armed_d = 1'b1;
      end
    end

    always_ff @(posedge clk_5M) begin
      if (Rst) begin
        hold_q  <= '0;
        armed_q <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        armed_q <= armed_d;
      end
    end

    assign w_fire[gr] = fire;
  end
`else
  assign w_fire = '0;
`endif

  always_ff @(posedge clk_5M) begin
    if (Rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      level_d1_q <= '0;
      press_q    <= '0;
      release_q  <= '0;
      repeat_q   <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      level_q    <= level_q ^ w_flip;
      level_d1_q <= level_q;
      press_q    <= level_q & ~level_d1_q;
      release_q  <= ~level_q & level_d1_q;
      repeat_q   <= w_fire;
    end
  end

  assign w_valid = |pend_q;

  // Fixed priority: the lowest pending index is presented first.
  always_comb begin
    w_code = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        w_code = KW'(i);
      end
    end
  end

  always_comb begin
    w_set = press_q | repeat_q;
    w_clr = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (key_ack && w_valid && (w_code == KW'(i))) begin
        w_clr[i] = 1'b1;
      end
    end
    // Set is OR-ed in after the clear so a coincident set wins.
    pend_d    = (pend_q & ~w_clr) | w_set;
    overrun_d = overrun_q | (|(w_set & pend_q & ~w_clr));
  end

  always_ff @(posedge clk_5M) begin
    if (Rst) begin
      pend_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;
  assign key_valid   = w_valid;
  assign key_code    = w_code;
  assign key_overrun = overrun_q;

endmodule
`default_nettype wire
